// File: rtl/aes_pkg.sv
// Shared constants for the AES datapath: state/key widths, XMM register indices
// and the clear-sweep FSM state encoding.
package aes_pkg;
   localparam int W_STATE = 128;
   localparam int W_KEY   = 128;

   localparam logic [3:0] XMM0  = 4'd0,  XMM1  = 4'd1,  XMM2  = 4'd2,  XMM3  = 4'd3;
   localparam logic [3:0] XMM4  = 4'd4,  XMM5  = 4'd5,  XMM6  = 4'd6,  XMM7  = 4'd7;
   localparam logic [3:0] XMM8  = 4'd8,  XMM9  = 4'd9,  XMM10 = 4'd10, XMM11 = 4'd11;
   localparam logic [3:0] XMM12 = 4'd12, XMM13 = 4'd13, XMM14 = 4'd14, XMM15 = 4'd15;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;
endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep controller: on clr_req walks an index 0..NREGS-1, one register per
// cycle, and reports busy while sweeping.
module regfile_clr_fsm
   import aes_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          busy,
   output logic [AW-1:0] clr_idx
);
   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   clr_state_t    state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // clr_req is only looked at in IDLE, so a request during a sweep never restarts it
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            busy = 1'b1;
            if (cnt == LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign clr_idx = cnt;
endmodule

// File: rtl/xmm_regfile.sv
// XMM register file: one byte-enabled write port, two registered read ports
// (data/key), clear sweep. Define XMM_REGFILE_BYPASS_EN for write-to-read forwarding.
module xmm_regfile
   import aes_pkg::*;
#(
   parameter int W     = 128,
   parameter int NREGS = 16,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           wr_valid,
   output logic           wr_ready,
   input  logic [AW-1:0]  wr_addr,
   input  logic [W-1:0]   wr_data,
   input  logic [W/8-1:0] wr_be,
   input  logic           rd_en,
   input  logic [AW-1:0]  data_reg,
   input  logic [AW-1:0]  key_reg,
   output logic [W-1:0]   data,
   output logic [W-1:0]   key,
   output logic           rd_valid,
   input  logic           clr_req,
   output logic           busy
);
`ifdef XMM_REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [W-1:0]  rf [NREGS];
   logic [AW-1:0] clr_idx;
   logic          wr_fire;
   logic [W-1:0]  data_nxt, key_nxt;

   function automatic logic [W-1:0] be_merge(input logic [W-1:0]   old_v,
                                             input logic [W-1:0]   new_v,
                                             input logic [W/8-1:0] be);
      logic [W-1:0] res;
      res = old_v;
      for (int i = 0; i < W/8; i++)
         if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      return res;
   endfunction

   // Indices past NREGS exist only when NREGS is not a power of two
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return 32'(a) < 32'(NREGS);
   endfunction

   regfile_clr_fsm #(.NREGS(NREGS), .AW(AW)) u_clr (
      .clk     (clk),
      .rst     (rst),
      .clr_req (clr_req),
      .busy    (busy),
      .clr_idx (clr_idx)
   );

   assign wr_ready = ~busy;
   assign wr_fire  = wr_valid & wr_ready;

   // Storage: sweep and write never overlap because wr_ready is low during the sweep
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else if (busy) begin
         rf[clr_idx] <= '0;
      end else if (wr_fire && addr_ok(wr_addr)) begin
         rf[wr_addr] <= be_merge(rf[wr_addr], wr_data, wr_be);
      end
   end

   always_comb begin
      data_nxt = '0;
      key_nxt  = '0;
      if (addr_ok(data_reg)) begin
         data_nxt = rf[data_reg];
         if (BYPASS && wr_fire && (data_reg == wr_addr))
            data_nxt = be_merge(rf[data_reg], wr_data, wr_be);
      end
      if (addr_ok(key_reg)) begin
         key_nxt = rf[key_reg];
         if (BYPASS && wr_fire && (key_reg == wr_addr))
            key_nxt = be_merge(rf[key_reg], wr_data, wr_be);
      end
   end

   // Read stage: one-cycle latency, outputs hold between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data     <= '0;
         key      <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            data <= data_nxt;
            key  <= key_nxt;
         end
      end
   end
endmodule
